// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier: one 2x2 Vedic cell walks all N*N digit pairs,
// accumulating shifted partial products under a valid/ready start/result handshake.

module vedic2bmul (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic c1;

    // Urdhva-tiryagbhyam: vertical and crosswise products with carry
    assign c1     = a_i[1] & b_i[0] & a_i[0] & b_i[1];
    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
    assign p_o[2] = (a_i[1] & b_i[1]) ^ c1;
    assign p_o[3] = a_i[1] & b_i[1] & c1;
endmodule

module mul_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 flush,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = CW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       i_q, i_d;
    logic [CW-1:0]       j_q, j_d;

    logic                accept_c;
    logic                last_j_c;
    logic                last_i_c;
    logic [WIDTH-1:0]    a_sh_c;
    logic [WIDTH-1:0]    b_sh_c;
    logic [3:0]          pp_c;
    logic [SW-1:0]       shamt_c;
    logic [PW-1:0]       pp_ext_c;

    // Digit selection and weighting of the current partial product
    assign a_sh_c   = a_q >> {i_q, 1'b0};
    assign b_sh_c   = b_q >> {j_q, 1'b0};
    assign shamt_c  = (SW'(i_q) + SW'(j_q)) << 1;
    assign pp_ext_c = PW'(pp_c) << shamt_c;

    vedic2bmul u_vedic (
        .a_i (a_sh_c[1:0]),
        .b_i (b_sh_c[1:0]),
        .p_o (pp_c)
    );

    assign start_ready = !flush &&
                         ((state_q == IDLE) || ((state_q == DONE) && result_ready));
    assign accept_c    = start_valid && start_ready;
    assign last_j_c    = (j_q == CW'(N - 1));
    assign last_i_c    = (i_q == CW'(N - 1));

    assign result_valid = (state_q == DONE);
    assign busy         = (state_q == BUSY);
    assign product      = acc_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;

        // Flush wins over everything; the accumulator keeps its last value
        if (flush) begin
            state_d = IDLE;
            i_d     = '0;
            j_d     = '0;
        end else if (accept_c) begin
            state_d = BUSY;
            a_d     = op_a;
            b_d     = op_b;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
        end else begin
            unique case (state_q)
                BUSY: begin
                    acc_d = acc_q + pp_ext_c;
                    if (last_j_c) begin
                        j_d = '0;
                        if (last_i_c) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + CW'(1);
                        end
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end
endmodule
